// File: rtl/mau_pkg.sv
// Shared encodings and helpers for the memory access unit.
package mau_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Width of the byte-lane index inside one bus beat.
  function automatic int lane_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/mau_if.sv
// Pipeline-side and bus-side signals of the memory access unit.
interface mau_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              Bus_req;
  logic              Bus_ack;
  logic [ADDR_W-1:0] Bus_addr;
  logic              Bus_we;
  logic [DATA_W/8-1:0] Bus_wstrb;
  logic [DATA_W-1:0] Bus_wdata;
  logic [DATA_W-1:0] Bus_rdata;

  modport master (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, Bus_ack, Bus_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, Bus_req, Bus_addr, Bus_we, Bus_wstrb, Bus_wdata
  );

  modport slave (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, Bus_ack, Bus_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, Bus_req, Bus_addr, Bus_we, Bus_wstrb, Bus_wdata
  );
endinterface

// File: rtl/mau_lane_align.sv
// Byte-lane steering: store strobes/data onto lanes, load extraction and extension.
module mau_lane_align
  import mau_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NB     = DATA_W / 8,
  parameter int LW     = lane_w(DATA_W)
) (
  input  logic [1:0]        size,
  input  logic [LW-1:0]     lane,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [NB-1:0]     wstrb,
  output logic [DATA_W-1:0] wdata_lanes,
  output logic [DATA_W-1:0] rdata_ext
);

  logic [NB-1:0]     bmask_s;
  logic [DATA_W-1:0] dmask_s;
  logic [DATA_W-1:0] shifted_s;
  logic              sign_s;
  int                nbytes_s;

  // Access-size byte mask, then shift it and the data into lane position.
  always_comb begin
    nbytes_s = int'(4'd1 << size);
    for (int i = 0; i < NB; i++) begin
      bmask_s[i] = (i < nbytes_s);
    end
    for (int b = 0; b < DATA_W; b++) begin
      dmask_s[b] = bmask_s[b / 8];
    end
    wstrb       = bmask_s << lane;
    wdata_lanes = (wdata & dmask_s) << {lane, 3'b000};
    shifted_s   = rdata >> {lane, 3'b000};
    case (size)
      SZ_B:    sign_s = shifted_s[7];
      SZ_H:    sign_s = shifted_s[15];
      SZ_W:    sign_s = shifted_s[31];
      default: sign_s = shifted_s[DATA_W-1];
    endcase
    for (int b = 0; b < DATA_W; b++) begin
      rdata_ext[b] = dmask_s[b] ? shifted_s[b] : (sign_s & ~is_unsigned);
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store bus master: req/ack toward the bus, ready/valid toward the pipeline.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input logic  cpu_clk,
  input logic  cpu_rst,
  mau_if.master io
);

  localparam int NB = DATA_W / 8;
  localparam int LW = lane_w(DATA_W);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t            state_r, state_s;
  logic [TW-1:0]     timer_r;
  logic [1:0]        size_r;
  logic              uns_r;
  logic [LW-1:0]     lane_r;
  logic              bus_req_r, bus_we_r;
  logic [ADDR_W-1:0] bus_addr_r;
  logic [NB-1:0]     bus_wstrb_r;
  logic [DATA_W-1:0] bus_wdata_r;
  logic              rsp_valid_r, rsp_err_r;
  logic [DATA_W-1:0] rsp_rdata_r;
  logic              accept_s, illegal_s, ack_s, timeout_s;
  logic [1:0]        al_size_s;
  logic [LW-1:0]     al_lane_s;
  logic [NB-1:0]     al_wstrb_s;
  logic [DATA_W-1:0] al_wdata_s, al_rdata_s;

  // Misalignment and unsupported-size detection on the incoming request.
  always_comb begin
    case (io.req_size)
      SZ_B:    illegal_s = 1'b0;
      SZ_H:    illegal_s = io.req_addr[0];
      SZ_W:    illegal_s = |io.req_addr[1:0];
      SZ_D:    illegal_s = (DATA_W == 32) ? 1'b1 : |io.req_addr[2:0];
      default: illegal_s = 1'b1;
    endcase
  end

  // Next-state logic; an ack on the timeout edge still completes normally.
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    ack_s     = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (io.req_valid) begin
          accept_s = 1'b1;
          state_s  = illegal_s ? RESP : BUS;
        end else begin
          state_s = IDLE;
        end
      end
      BUS: begin
        if (io.Bus_ack) begin
          ack_s   = 1'b1;
          state_s = RESP;
        end else if (timer_r == TW'(TIMEOUT - 1)) begin
          timeout_s = 1'b1;
          state_s   = RESP;
        end else begin
          state_s = BUS;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) state_r <= IDLE;
    else          state_r <= state_s;
  end

  // Steering uses live request fields while idle, captured fields during the access.
  assign al_size_s = (state_r == IDLE) ? io.req_size : size_r;
  assign al_lane_s = (state_r == IDLE) ? io.req_addr[LW-1:0] : lane_r;

  mau_lane_align #(.DATA_W(DATA_W)) u_align (
    .size        (al_size_s),
    .lane        (al_lane_s),
    .is_unsigned (uns_r),
    .wdata       (io.req_wdata),
    .rdata       (io.Bus_rdata),
    .wstrb       (al_wstrb_s),
    .wdata_lanes (al_wdata_s),
    .rdata_ext   (al_rdata_s)
  );

  // Request capture, bus drive registers, timer and response registers.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      timer_r     <= '0;
      size_r      <= 2'd0;
      uns_r       <= 1'b0;
      lane_r      <= '0;
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_addr_r  <= '0;
      bus_wstrb_r <= '0;
      bus_wdata_r <= '0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= '0;
    end else begin
      rsp_valid_r <= 1'b0;
      if (accept_s) begin
        size_r  <= io.req_size;
        uns_r   <= io.req_unsigned;
        lane_r  <= io.req_addr[LW-1:0];
        timer_r <= '0;
        if (illegal_s) begin
          rsp_valid_r <= 1'b1;
          rsp_err_r   <= 1'b1;
          rsp_rdata_r <= '0;
        end else begin
          bus_req_r   <= 1'b1;
          bus_we_r    <= io.req_we;
          bus_addr_r  <= {io.req_addr[ADDR_W-1:LW], {LW{1'b0}}};
          bus_wstrb_r <= io.req_we ? al_wstrb_s : '0;
          bus_wdata_r <= io.req_we ? al_wdata_s : '0;
        end
      end else if (ack_s || timeout_s) begin
        bus_req_r   <= 1'b0;
        rsp_valid_r <= 1'b1;
        rsp_err_r   <= timeout_s;
        rsp_rdata_r <= (ack_s && !bus_we_r) ? al_rdata_s : '0;
      end else if (state_r == BUS) begin
        timer_r <= timer_r + TW'(1);
      end
    end
  end

  assign io.req_ready = (state_r == IDLE);
  assign io.rsp_valid = rsp_valid_r;
  assign io.rsp_err   = rsp_err_r;
  assign io.rsp_rdata = rsp_rdata_r;
  assign io.Bus_req   = bus_req_r;
  assign io.Bus_we    = bus_we_r;
  assign io.Bus_addr  = bus_addr_r;
  assign io.Bus_wstrb = bus_wstrb_r;
  assign io.Bus_wdata = bus_wdata_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 32-bit unit (TIMEOUT=4) and a 64-bit unit (TIMEOUT=15).
module tb_mem_access_unit;
  import mau_pkg::*;

  logic cpu_clk = 1'b0;
  logic cpu_rst = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  mau_if #(.ADDR_W(32), .DATA_W(32)) i32 ();
  mau_if #(.ADDR_W(32), .DATA_W(64)) i64 ();

  mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut32 (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .io(i32.master));
  mem_access_unit #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(15)) dut64 (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .io(i64.master));

  logic        sel = 1'b0, vld = 1'b0, ack = 1'b0, we = 1'b0, uns = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] addr = 32'h0;
  logic [63:0] wdata = 64'h0, rdata = 64'h0;

  assign i32.req_valid = vld & ~sel;   assign i64.req_valid = vld & sel;
  assign i32.Bus_ack   = ack & ~sel;   assign i64.Bus_ack   = ack & sel;
  assign i32.req_we = we;              assign i64.req_we = we;
  assign i32.req_size = size;          assign i64.req_size = size;
  assign i32.req_unsigned = uns;       assign i64.req_unsigned = uns;
  assign i32.req_addr = addr;          assign i64.req_addr = addr;
  assign i32.req_wdata = wdata[31:0];  assign i64.req_wdata = wdata;
  assign i32.Bus_rdata = rdata[31:0];  assign i64.Bus_rdata = rdata;

  logic        o_rdy, o_rv, o_err, o_breq, o_bwe;
  logic [31:0] o_baddr;
  logic [7:0]  o_wstrb;
  logic [63:0] o_rdata, o_wdata;

  always_comb begin
    if (sel) begin
      o_rdy = i64.req_ready; o_rv = i64.rsp_valid; o_err = i64.rsp_err; o_breq = i64.Bus_req;
      o_bwe = i64.Bus_we; o_baddr = i64.Bus_addr; o_wstrb = i64.Bus_wstrb;
      o_rdata = i64.rsp_rdata; o_wdata = i64.Bus_wdata;
    end else begin
      o_rdy = i32.req_ready; o_rv = i32.rsp_valid; o_err = i32.rsp_err; o_breq = i32.Bus_req;
      o_bwe = i32.Bus_we; o_baddr = i32.Bus_addr; o_wstrb = {4'h0, i32.Bus_wstrb};
      o_rdata = {32'h0, i32.rsp_rdata}; o_wdata = {32'h0, i32.Bus_wdata};
    end
  end

  int total = 0;
  int bad = 0;
  logic [31:0] last_baddr;
  logic [7:0]  last_wstrb;
  logic [63:0] last_wdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: what one access should look like, from byte-lane arithmetic.
  task automatic model(input bit is64, input bit w, input logic [1:0] sz, input bit u,
                       input logic [31:0] a, input logic [63:0] wd, input logic [63:0] rd,
                       output bit ill, output logic [31:0] ea, output logic [7:0] es,
                       output logic [63:0] ew, output logic [63:0] er);
    int nb, n, lane;
    logic [63:0] m, dm, v;
    nb   = is64 ? 8 : 4;
    n    = 1 << sz;
    lane = int'(a % 32'(nb));
    m    = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
    dm   = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    ill  = (sz == 2'd3 && !is64) || (a % 32'(n) != 32'd0);
    ea   = a - 32'(lane);
    es   = w ? 8'(((1 << n) - 1) << lane) : 8'h00;
    ew   = w ? (((wd & m) << (8 * lane)) & dm) : 64'h0;
    v    = (rd >> (8 * lane)) & m;
    if (!u && v > (m >> 1)) v = v | ~m;
    er   = (w || ill) ? 64'h0 : (v & dm);
  endtask

  // One access; dly = cycle of Bus_req in which ack is given (0 = never).
  task automatic txn(input bit s, input bit w, input logic [1:0] sz, input bit u,
                     input logic [31:0] a, input logic [63:0] wd, input logic [63:0] rd,
                     input int dly);
    bit ill, ok;
    logic [31:0] ea;
    logic [7:0]  es;
    logic [63:0] ew, er;
    int to;
    to = s ? 15 : 4;
    model(s, w, sz, u, a, wd, rd, ill, ea, es, ew, er);
    @(negedge cpu_clk);
    sel = s; we = w; size = sz; uns = u; addr = a; wdata = wd; rdata = rd; vld = 1'b1;
    #1;
    chk("ready_idle", o_rdy, 1'b1);
    @(negedge cpu_clk);
    vld = 1'b0;
    if (ill) begin
      chk("ill_valid", o_rv, 1'b1);
      chk("ill_err", o_err, 1'b1);
      chk("ill_rdata", o_rdata, 64'h0);
      chk("ill_busreq", o_breq, 1'b0);
    end else begin
      chk("bus_addr", o_baddr, ea);
      chk("bus_we", o_bwe, w);
      chk("bus_wstrb", o_wstrb, es);
      chk("bus_wdata", o_wdata, ew);
      last_baddr = o_baddr; last_wstrb = o_wstrb; last_wdata = o_wdata;
      ok = (dly >= 1 && dly <= to);
      for (int k = 1; k <= to; k++) begin
        chk("bus_req_high", o_breq, 1'b1);
        chk("bus_addr_hold", o_baddr, ea);
        chk("no_early_rsp", o_rv, 1'b0);
        if (k == dly) ack = 1'b1;
        @(negedge cpu_clk);
        ack = 1'b0;
        if (k == dly) break;
      end
      chk("rsp_valid", o_rv, 1'b1);
      chk("rsp_err", o_err, !ok);
      chk("rsp_rdata", o_rdata, ok ? er : 64'h0);
      chk("bus_req_drop", o_breq, 1'b0);
    end
    @(negedge cpu_clk);
    chk("rsp_pulse", o_rv, 1'b0);
    chk("ready_again", o_rdy, 1'b1);
  endtask

  initial begin
    repeat (3) @(posedge cpu_clk);
    @(negedge cpu_clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_ready", o_rdy, 1'b1);
      chk("rst_rv", o_rv, 1'b0);
      chk("rst_err", o_err, 1'b0);
      chk("rst_rdata", o_rdata, 64'h0);
      chk("rst_breq", o_breq, 1'b0);
      chk("rst_bwe", o_bwe, 1'b0);
      chk("rst_wstrb", o_wstrb, 8'h0);
      chk("rst_baddr", o_baddr, 32'h0);
      chk("rst_wdata", o_wdata, 64'h0);
    end
    cpu_rst = 1'b1;

    txn(1'b0, 1'b0, SZ_W, 1'b0, 32'h1004, 64'h0, 64'hDEADBEEF, 3);
    chk("word_load", o_rdata, 64'hDEADBEEF);
    chk("word_addr", last_baddr, 32'h1004);
    txn(1'b0, 1'b0, SZ_B, 1'b0, 32'h1003, 64'h0, 64'h80112233, 1);
    chk("sbyte_load", o_rdata, 64'hFFFFFF80);
    chk("load_wstrb", last_wstrb, 8'h0);
    txn(1'b0, 1'b0, SZ_B, 1'b1, 32'h1003, 64'h0, 64'h80112233, 1);
    chk("ubyte_load", o_rdata, 64'h00000080);
    txn(1'b0, 1'b1, SZ_H, 1'b0, 32'h2002, 64'hABCD, 64'h0, 2);
    chk("hstore_addr", last_baddr, 32'h2000);
    chk("hstore_wstrb", last_wstrb, 8'h0C);
    chk("hstore_wdata", last_wdata[31:16], 16'hABCD);
    chk("hstore_rdata", o_rdata, 64'h0);
    txn(1'b0, 1'b0, SZ_W, 1'b0, 32'h1002, 64'h0, 64'h0, 1);
    txn(1'b0, 1'b0, SZ_W, 1'b0, 32'h1008, 64'h0, 64'h12345678, 0);
    txn(1'b0, 1'b0, SZ_W, 1'b0, 32'h1008, 64'h0, 64'h12345678, 4);
    chk("ack_on_timeout_edge", o_rdata, 64'h12345678);
    txn(1'b0, 1'b0, SZ_D, 1'b0, 32'h0008, 64'h0, 64'h0, 1);

    // Reset in the middle of an access, then a stray ack.
    @(negedge cpu_clk);
    sel = 1'b0; we = 1'b0; size = SZ_W; addr = 32'h3000; vld = 1'b1;
    @(negedge cpu_clk);
    vld = 1'b0;
    chk("mid_breq", o_breq, 1'b1);
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    @(negedge cpu_clk);
    cpu_rst = 1'b1;
    chk("mid_rst_breq", o_breq, 1'b0);
    chk("mid_rst_ready", o_rdy, 1'b1);
    ack = 1'b1;
    @(negedge cpu_clk);
    ack = 1'b0;
    chk("stray_ack_rv", o_rv, 1'b0);
    chk("stray_ack_ready", o_rdy, 1'b1);
    @(negedge cpu_clk);
    chk("stray_ack_rv2", o_rv, 1'b0);

    txn(1'b1, 1'b0, SZ_D, 1'b0, 32'h0008, 64'h0, 64'h0123456789ABCDEF, 2);
    chk("dword_load", o_rdata, 64'h0123456789ABCDEF);
    chk("dword_wstrb", last_wstrb, 8'h0);
    txn(1'b1, 1'b1, SZ_B, 1'b0, 32'h0015, 64'h5A, 64'h0, 1);
    chk("b64_wstrb", last_wstrb, 8'h20);

    for (int i = 0; i < 60; i++) begin
      bit s, w, u;
      logic [1:0] sz;
      logic [31:0] a;
      int dly;
      s   = 1'($urandom_range(0, 1));
      w   = 1'($urandom_range(0, 1));
      u   = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      a   = $urandom & 32'h0000_FFFF;
      if ($urandom_range(0, 9) < 7) a = a & ~(32'(1 << sz) - 32'd1);
      dly = s ? int'($urandom_range(0, 17)) : int'($urandom_range(0, 6));
      txn(s, w, sz, u, a, {$urandom, $urandom}, {$urandom, $urandom}, dly);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

endmodule
